iir_biquad_cascade: RTL and testbench
=====================================

Name: iir_biquad_cascade

Overview:
Parametrised, time-multiplexed IIR filter: a cascade of N_SEC Direct-Form-I biquad sections sharing one multiplier-accumulator. It is the next generation of the team's fixed 24-bit audio IIR. It adds a valid/ready input handshake, run-time loadable coefficients, a bypass mode and a state-clear. It sits between the audio sample source and the sample sink, one sample per handshake.

Parameters:
WD_DATA, 24, signed width of in_data and out_data.
WD_COEF, 18, signed coefficient width.
FRAC, 16, coefficient fraction bits; default format is Q2.16, range [-2.0, 2.0).
N_SEC, 4, number of cascaded biquad sections, 1..8.
WD_ACC, WD_DATA+WD_COEF+3, accumulator width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  WD_DATA  signed input sample
bypass  in  1  sampled at handshake; 1 = pass sample through unfiltered
clear_state  in  1  zero all delay lines; honoured only in IDLE
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(5*N_SEC)  slot = sec*5+k, where k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
coef_data  in  WD_COEF  signed coefficient
coef_drop  out  1  one-cycle pulse: a write was dropped
out_valid  out  1  one-cycle pulse: new result on out_data
out_data  out  WD_DATA  signed filtered sample; held until the next result

Behaviour:
- Reset (async, active-high):
  - All delay registers (x1, x2, y1, y2 per section) = 0.
  - Coefficients: b0 = 1<<FRAC (1.0), all others 0, so the cascade passes samples through.
  - out_valid=0, out_data=0, coef_drop=0.
  - in_ready=0 while reset is high; in_ready=1 on the first clock after release.
- Section equation: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2.
  - Section s>0 takes section s-1's output as its x.
- FSM states: IDLE, MAC, WRAP, DONE, BYP.
  - IDLE: in_ready=1. On in_valid&in_ready:
    - bypass=1: go to BYP.
    - otherwise: latch in_data, sec=0, k=0, acc=0, go to MAC.
  - MAC: one product per cycle for k=0..4; acc += or -= product; 5 cycles, then WRAP.
  - WRAP (1 cycle):
    - r = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round-half-up, arithmetic shift.
    - Saturate r to [-2^(WD_DATA-1), 2^(WD_DATA-1)-1].
    - Shift the section's delay line: x2<=x1, x1<=x, y2<=y1, y1<=r.
    - If sec<N_SEC-1: sec++, x=r, go to MAC. Else go to DONE.
  - DONE: out_data<=final r, out_valid=1 for this cycle, in_ready=0; next state IDLE.
  - BYP: out_data<=latched sample, out_valid=1; delay lines untouched; next state IDLE.
- Latency: out_valid rises 6*N_SEC+1 cycles after the accepting edge (25 at default). Bypass latency is 1 cycle.
- Throughput: one sample per 6*N_SEC+2 cycles with in_valid held high.
- in_ready=0 in MAC, WRAP, DONE and BYP; in_data is ignored there.
- Coefficient writes:
  - Accepted only in IDLE and take effect next cycle.
  - A write in any other state is dropped and coef_drop pulses the following cycle.
  - A write to an address >= 5*N_SEC is ignored silently.
- clear_state in IDLE zeroes all delay lines next cycle; elsewhere it is ignored.
- Simultaneous clear_state and handshake in IDLE: clear takes priority; the sample is accepted and processed with zeroed state.
- Simultaneous coef_we and handshake in IDLE: the write lands before the first MAC cycle uses it.
- Reset mid-operation: the computation is abandoned, out_valid is never raised for that sample, and all registers return to reset values.

Test Plan:
- Default coefs, in_data=0x123456 -> out_valid exactly 25 cycles after handshake, out_data=0x123456.
- Set sec0 b0=0x08000 (0.5) and a1=0x38000 (-0.5); impulse 0x100000 then zeros -> outputs 0x080000, 0x040000, 0x020000, 0x010000.
- Set sec0 b0=0x1FFFF; input 0x7FFFFF -> 0x7FFFFF (saturated high); input 0x800000 -> 0x800000 (saturated low).
- in_valid held high, samples 1,2,3 -> exactly one accepted per 26 cycles; in_ready low 25 cycles after each accept.
- coef_we during MAC -> coef_drop pulses once and the coefficient is unchanged; bypass=1 with 0xABCDEF -> out_data=0xABCDEF one cycle later, and the next filtered sample is unaffected.
- Assert reset 10 cycles after handshake -> no out_valid, out_data=0, in_ready=1 one cycle after release, coefficients back to identity.

Source files
------------

// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed cascade of N_SEC DF-I biquads sharing one MAC; one sample per valid/ready handshake.
// Latency 6*N_SEC+1 cycles (bypass: 1); in_ready is low from accept until the result has been presented.
module iir_biquad_cascade #(
   parameter int WD_DATA = 24,
   parameter int WD_COEF = 18,
   parameter int FRAC    = 16,
   parameter int N_SEC   = 4,
   parameter int WD_ACC  = WD_DATA + WD_COEF + 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [WD_DATA-1:0]     in_data,
   input  logic                          bypass,
   input  logic                          clear_state,
   input  logic                          coef_we,
   input  logic [$clog2(5*N_SEC)-1:0]    coef_addr,
   input  logic signed [WD_COEF-1:0]     coef_data,
   output logic                          coef_drop,
   output logic                          out_valid,
   output logic signed [WD_DATA-1:0]     out_data
);

   localparam int WA     = $clog2(5*N_SEC);
   localparam int N_COEF = 5*N_SEC;
   localparam int WS     = (N_SEC > 1) ? $clog2(N_SEC) : 1;
   localparam int WP     = WD_DATA + WD_COEF;

   localparam logic signed [WD_COEF-1:0] B0_ONE = WD_COEF'(1 << FRAC);
   localparam logic signed [WD_ACC-1:0]  HALF   = WD_ACC'(1 << (FRAC-1));
   localparam logic signed [WD_DATA-1:0] D_MAX  = {1'b0, {(WD_DATA-1){1'b1}}};
   localparam logic signed [WD_DATA-1:0] D_MIN  = {1'b1, {(WD_DATA-1){1'b0}}};
   localparam logic [WS-1:0]             LAST   = WS'(N_SEC-1);

   typedef enum logic [2:0] {IDLE, MAC, WRAP, DONE, BYP} state_t;

   state_t                     state, state_nxt;
   logic [2:0]                 k;
   logic [WS-1:0]              sec;
   logic signed [WD_ACC-1:0]   acc;
   logic signed [WD_DATA-1:0]  x_cur;
   logic                       rdy;

   logic signed [WD_COEF-1:0]  coef [N_COEF];
   logic signed [WD_DATA-1:0]  x1 [N_SEC];
   logic signed [WD_DATA-1:0]  x2 [N_SEC];
   logic signed [WD_DATA-1:0]  y1 [N_SEC];
   logic signed [WD_DATA-1:0]  y2 [N_SEC];

   logic                       accept, coef_wr, coef_bad, last_sec;
   logic [WA-1:0]              cidx;
   logic signed [WD_DATA-1:0]  op;
   logic signed [WD_COEF-1:0]  cf;
   logic signed [WP-1:0]       prod;
   logic signed [WD_ACC-1:0]   prod_ext, rnd, shf;
   logic signed [WD_DATA-1:0]  r_sat;
   logic                       ovf;

   assign in_ready = rdy;
   assign accept   = in_valid & rdy;
   assign last_sec = (sec == LAST);
   assign coef_wr  = coef_we && (state == IDLE) && ({1'b0, coef_addr} < (WA+1)'(N_COEF));
   assign coef_bad = coef_we && (state != IDLE);
   assign cidx     = WA'(int'(sec) * 5 + int'(k));

   // Operand mux: k selects x, x1, x2, y1, y2 of the current section.
   always_comb begin
      op = '0;
      case (k)
         3'd0:    op = x_cur;
         3'd1:    op = x1[sec];
         3'd2:    op = x2[sec];
         3'd3:    op = y1[sec];
         3'd4:    op = y2[sec];
         default: op = '0;
      endcase
   end

   assign cf       = coef[cidx];
   assign prod     = cf * op;
   assign prod_ext = WD_ACC'(prod);
   assign rnd      = acc + HALF;
   assign shf      = rnd >>> FRAC;
   assign ovf      = (shf[WD_ACC-1:WD_DATA-1] != {(WD_ACC-WD_DATA+1){shf[WD_ACC-1]}});
   assign r_sat    = ovf ? (shf[WD_ACC-1] ? D_MIN : D_MAX) : shf[WD_DATA-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bypass ? BYP : MAC;
         MAC:     if (k == 3'd4) state_nxt = WRAP;
         WRAP:    state_nxt = last_sec ? DONE : MAC;
         DONE:    state_nxt = IDLE;
         BYP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         coef_drop <= 1'b0;
         x_cur     <= '0;
         acc       <= '0;
         k         <= '0;
         sec       <= '0;
      end else begin
         rdy       <= (state_nxt == IDLE);
         out_valid <= (state == DONE) || (state == BYP);
         coef_drop <= coef_bad;
         if ((state == DONE) || (state == BYP)) out_data <= x_cur;
         case (state)
            IDLE: if (accept) begin
               x_cur <= in_data;
               acc   <= '0;
               k     <= '0;
               sec   <= '0;
            end
            MAC: begin
               acc <= (k >= 3'd3) ? acc - prod_ext : acc + prod_ext;
               k   <= (k == 3'd4) ? 3'd0 : k + 3'd1;
            end
            WRAP: begin
               // The section result becomes the next section's input, and the final output.
               x_cur <= r_sat;
               acc   <= '0;
               if (!last_sec) sec <= sec + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_SEC; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
      end else if ((state == IDLE) && clear_state) begin
         for (int i = 0; i < N_SEC; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
      end else if (state == WRAP) begin
         x2[sec] <= x1[sec];
         x1[sec] <= x_cur;
         y2[sec] <= y1[sec];
         y1[sec] <= r_sat;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_COEF; i++) coef[i] <= ((i % 5) == 0) ? B0_ONE : '0;
      end else if (coef_wr) begin
         coef[coef_addr] <= coef_data;
      end
   end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Randomised bench for iir_biquad_cascade against a plain-arithmetic cascade model.
module tb_iir_biquad_cascade;
   localparam int N_SEC = 4;
   localparam int NC    = 5*N_SEC;
   localparam int LAT   = 6*N_SEC + 1;

   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, bypass = 1'b0, clear_state = 1'b0, coef_we = 1'b0;
   logic        in_ready, coef_drop, out_valid;
   logic [23:0] in_data = '0;
   logic [23:0] out_data;
   logic [4:0]  coef_addr = '0;
   logic [17:0] coef_data = '0;

   int     n_vec = 0, n_bad = 0;
   longint mc [NC];
   longint mx1 [N_SEC], mx2 [N_SEC], my1 [N_SEC], my2 [N_SEC];
   longint last_out = 0;

   iir_biquad_cascade dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .bypass(bypass), .clear_state(clear_state), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .coef_drop(coef_drop), .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint sx(input logic [23:0] v);
      return longint'($signed(v));
   endfunction

   task automatic model_clear();
      for (int s = 0; s < N_SEC; s++) begin
         mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) mc[i] = ((i % 5) == 0) ? 65536 : 0;
      model_clear();
   endtask

   // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded half-up, clamped to 24 bits
   task automatic model_run(input longint xin, output longint y);
      longint x, a, r;
      x = xin;
      for (int s = 0; s < N_SEC; s++) begin
         a = mc[5*s]*x + mc[5*s+1]*mx1[s] + mc[5*s+2]*mx2[s] - mc[5*s+3]*my1[s] - mc[5*s+4]*my2[s];
         r = (a + 32768) >>> 16;
         if (r > 8388607) r = 8388607;
         if (r < -8388608) r = -8388608;
         mx2[s] = mx1[s]; mx1[s] = x;
         my2[s] = my1[s]; my1[s] = r;
         x = r;
      end
      y = x;
   endtask

   task automatic write_coef(input int a, input longint v);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 5'(a); coef_data = 18'(v);
      @(negedge clk);
      coef_we = 1'b0;
      if (a < NC) mc[a] = v;
   endtask

   task automatic send_sample(input logic [23:0] d, input bit byp, input bit clr,
                              input bit we_same, input bit we_mid, input int wa, input longint wv);
      longint y;
      int     lat, drops, waitc;
      @(negedge clk);
      waitc = 0;
      while (!in_ready && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      chk("ready_wait", in_ready, 1);
      chk("out_hold", sx(out_data), last_out);
      in_valid = 1'b1; in_data = d; bypass = byp; clear_state = clr;
      coef_we = we_same; coef_addr = 5'(wa); coef_data = 18'(wv);
      if (we_same && wa < NC) mc[wa] = wv;
      if (clr) model_clear();
      if (byp) y = sx(d);
      else model_run(sx(d), y);
      @(posedge clk);
      lat = 0; drops = 0;
      @(negedge clk);
      in_valid = 1'b0; bypass = 1'b0; clear_state = 1'b0; coef_we = 1'b0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (we_mid && lat == 2) begin
            coef_we = 1'b1; coef_addr = 5'(wa); coef_data = 18'(wv);
         end
         if (lat == 3) coef_we = 1'b0;
         drops += int'(coef_drop);
      end
      chk("latency", lat, byp ? 1 : LAT);
      chk("out_data", sx(out_data), y);
      chk("coef_drop_cnt", drops, we_mid ? 1 : 0);
      @(negedge clk);
      chk("out_valid_pulse", out_valid, 0);
      last_out = y;
   endtask

   task automatic stream_test();
      int     acc_cyc [3];
      int     na, no, cyc, lows;
      bit     took;
      longint y;
      longint expq [$];
      na = 0; no = 0; cyc = 0; lows = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 24'd1;
      while ((na < 3 || no < 3) && cyc < 300) begin
         if (out_valid) begin
            if (expq.size() > 0) chk("stream_out", sx(out_data), expq.pop_front());
            else chk("stream_spurious", out_valid, 0);
            no++;
         end
         if (na == 1 && !in_ready) lows++;
         took = in_ready && in_valid;
         if (took) begin
            acc_cyc[na] = cyc;
            model_run(sx(in_data), y);
            expq.push_back(y);
            last_out = y;
            na++;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (took) begin
            if (na < 3) in_data = 24'(na + 1);
            else in_valid = 1'b0;
         end
      end
      chk("stream_accepts", na, 3);
      chk("stream_outputs", no, 3);
      chk("stream_gap1", acc_cyc[1] - acc_cyc[0], LAT + 1);
      chk("stream_gap2", acc_cyc[2] - acc_cyc[1], LAT + 1);
      chk("stream_rdy_low", lows, LAT);
   endtask

   task automatic reset_midop_test();
      int ov;
      @(negedge clk);
      in_valid = 1'b1; in_data = 24'h345678;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rm_rdy", in_ready, 0);
      chk("rm_ov", out_valid, 0);
      chk("rm_od", out_data, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rm_rdy_after", in_ready, 1);
      ov = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) ov++;
      end
      chk("rm_no_ov", ov, 0);
      chk("rm_od_idle", out_data, 0);
      model_reset();
      last_out = 0;
      send_sample(24'h5A5A5A, 0, 0, 0, 0, 0, 0);
      chk("rm_identity", out_data, 24'h5A5A5A);
   endtask

   initial begin
      logic [23:0] d;
      bit          byp, clr, wes, wem;
      int          wa;
      longint      wv;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_rdy", in_ready, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_od", out_data, 0);
      chk("rst_drop", coef_drop, 0);
      reset = 1'b0;
      chk("rdy_pre_edge", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("rdy_after_rst", in_ready, 1);

      send_sample(24'h123456, 0, 0, 0, 0, 0, 0);
      chk("identity", out_data, 24'h123456);

      stream_test();

      write_coef(0, 32768);
      write_coef(3, -32768);
      send_sample(24'h100000, 0, 1, 0, 0, 0, 0);
      chk("imp0", out_data, 24'h080000);
      send_sample(24'h000000, 0, 0, 0, 0, 0, 0);
      chk("imp1", out_data, 24'h040000);
      send_sample(24'h000000, 0, 0, 0, 0, 0, 0);
      chk("imp2", out_data, 24'h020000);
      send_sample(24'h000000, 0, 0, 0, 0, 0, 0);
      chk("imp3", out_data, 24'h010000);

      write_coef(3, 0);
      write_coef(0, 131071);
      send_sample(24'h7FFFFF, 0, 1, 0, 0, 0, 0);
      chk("sat_hi", out_data, 24'h7FFFFF);
      send_sample(24'h800000, 0, 0, 0, 0, 0, 0);
      chk("sat_lo", out_data, 24'h800000);

      write_coef(0, 65536);
      send_sample(24'h111111, 0, 0, 0, 1, 0, 0);
      chk("drop_keep", out_data, 24'h111111);
      send_sample(24'hABCDEF, 1, 0, 0, 0, 0, 0);
      chk("bypass", out_data, 24'hABCDEF);
      send_sample(24'h222222, 0, 0, 0, 0, 0, 0);
      chk("after_bypass", out_data, 24'h222222);

      reset_midop_test();

      for (int i = 0; i < NC; i++) begin
         if ((i % 5) < 3) write_coef(i, longint'($urandom_range(0, 65536)) - 32768);
         else             write_coef(i, longint'($urandom_range(0, 32768)) - 16384);
      end
      send_sample(24'($urandom), 0, 1, 0, 0, 0, 0);
      for (int n = 0; n < 40; n++) begin
         d   = 24'($urandom);
         byp = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 7) == 0);
         wes = ($urandom_range(0, 3) == 0);
         wem = !byp && !wes && ($urandom_range(0, 5) == 0);
         wa  = int'($urandom_range(0, 31));
         if ((wa % 5) < 3) wv = longint'($urandom_range(0, 65536)) - 32768;
         else              wv = longint'($urandom_range(0, 32768)) - 16384;
         send_sample(d, byp, clr, wes, wem, wa, wv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
